stdout_uart_tx: RTL and testbench
=================================

STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, entries in the byte buffer; power of two, range 2..64.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 stdout_write_enable  input  1  byte write request, driven from the decoded stdout instruction.
REQ-006 stdout_data  input  8  byte to transmit (rs2[7:0]).
REQ-007 stdout_ready  output  1  buffer can accept a byte; the core stalls the stdout instruction while 0.
REQ-008 txd  output  1  UART serial line; idle high.
REQ-009 busy  output  1  buffer non-empty or a frame is in progress.

Function
REQ-010 A byte SHALL be accepted on a rising clk edge only when stdout_write_enable=1 and stdout_ready=1; otherwise stdout_data is ignored.
REQ-011 stdout_ready SHALL be registered and equal 0 exactly while the buffer holds FIFO_DEPTH entries; a pop and a write request in the same cycle while full SHALL NOT accept the write.
REQ-012 When not full, a simultaneous write and pop SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-013 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-014 The transmitter FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
REQ-015 IDLE: txd=1; if the buffer is non-empty, pop the head byte into the shift register and go to START on the next edge.
REQ-016 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits sent LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit counter selects the bit; after bit 7, go to STOP (or PARITY).
REQ-018 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE; back-to-back bytes SHALL have exactly one stop bit between frames (no extra idle bit beyond the single IDLE cycle).
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state transition; its width is $clog2(CLKS_PER_BIT).
REQ-020 Latency: first start-bit edge on txd SHALL occur 2 cycles after a write is accepted into an empty buffer with the FSM in IDLE.
REQ-021 txd SHALL be driven from a flop (glitch-free).
REQ-022 busy SHALL be 1 whenever the FSM is not IDLE or the buffer is non-empty.

Reset
REQ-023 While rstn=0: FSM=IDLE, pointers=0, counters=0, txd=1, stdout_ready=1, busy=0; reset mid-frame SHALL abort the frame and discard buffered bytes.

Configuration
REQ-024 Macro STDOUT_UART_PARITY_EN: when defined, a PARITY state between DATA and STOP SHALL send even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; when undefined, PARITY state and logic SHALL be absent and DATA goes directly to STOP.

Structure
REQ-025 Shared package SHALL hold the FSM state enum, DEFAULT_CLKS_PER_BIT=868 and DEFAULT_STDOUT_FIFO_DEPTH=8.
REQ-026 The buffer SHALL be a sub-module stdout_fifo (push/pop/full/empty, parameterised depth and width); the FSM and baud counter live in stdout_uart_tx.

Verification
REQ-027 CLKS_PER_BIT=4, write 0x55 into empty buffer -> txd low at cycle 2 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles; busy falls after stop bit.
REQ-028 FIFO_DEPTH=4, write 0x01..0x05 on consecutive cycles -> stdout_ready=0 after the 4th (or 5th, once one byte is popped) accept; all accepted bytes are transmitted in order; no byte is lost or duplicated.
REQ-029 Buffer full, write asserted in the same cycle the FSM pops -> write not accepted; next cycle stdout_ready=1 and the retried write is accepted.
REQ-030 rstn pulsed low during DATA bit 3 of 0xA5 with 2 bytes buffered -> txd=1 immediately, busy=0, stdout_ready=1; no further frames.
REQ-031 STDOUT_UART_PARITY_EN defined, send 0x07 -> parity bit 1 between bit 7 and stop; send 0x03 -> parity bit 0; undefined -> frame of 10 bits exactly.
REQ-032 Two bytes 0xFF, 0x00 back-to-back, CLKS_PER_BIT=4 -> stop bit of first frame followed by start bit of second after exactly one IDLE cycle.

Source files
------------

// File: rtl/stdout_uart_tx_pkg.sv
// Shared types and defaults for the stdout UART transmitter.
// Define STDOUT_UART_PARITY_EN to add the PARITY state to the FSM encoding.
package stdout_uart_tx_pkg;

   localparam int DEFAULT_CLKS_PER_BIT      = 868;
   localparam int DEFAULT_STDOUT_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef STDOUT_UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/stdout_uart_tx_if.sv
// Byte write handshake between the core's stdout instruction and the UART buffer.
interface stdout_uart_tx_if;
   logic       stdout_write_enable;
   logic [7:0] stdout_data;
   logic       stdout_ready;

   modport master (output stdout_write_enable, output stdout_data, input stdout_ready);
   modport slave  (input stdout_write_enable, input stdout_data, output stdout_ready);
endinterface

// File: rtl/stdout_uart_tx_fifo.sv
// stdout_fifo: circular byte buffer with wrap-bit pointers and a registered full flag.
module stdout_fifo
   import stdout_uart_tx_pkg::*;
#(
   parameter int DEPTH = DEFAULT_STDOUT_FIFO_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             push_ok, pop_ok;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = full_q;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      push_ok  = push & ~full_q;
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
      // Full is computed from the next pointers so the flag itself can be a flop.
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: buffered 8N1 UART transmitter fed by the core's stdout instruction.
// Define STDOUT_UART_PARITY_EN to send an even-parity bit between data and stop.
module stdout_uart_tx
   import stdout_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEFAULT_STDOUT_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rstn,
   stdout_uart_tx_if.slave bus,
   output logic            txd,
   output logic            busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   tx_state_e  state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       txd_q, txd_d;
   logic       busy_q, busy_d;
   logic       push, pop, fifo_full, fifo_empty, baud_last, line;
   logic [7:0] fifo_head;

   assign push             = bus.stdout_write_enable & ~fifo_full;
   assign bus.stdout_ready = ~fifo_full;
   assign baud_last        = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
   assign txd              = txd_q;
   assign busy             = busy_q;

   stdout_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (bus.stdout_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      pop       = 1'b0;
      line      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_head;
               state_d = ST_START;
            end
         end
         ST_START: begin
            line = 1'b0;
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            // The byte stays intact so parity can be taken from it afterwards.
            line = shreg_q[bit_idx_q];
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef STDOUT_UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef STDOUT_UART_PARITY_EN
         ST_PARITY: begin
            line = ^shreg_q;
            if (baud_last) begin
               baud_d  = '0;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
      txd_d  = line;
      // Registered alongside txd so busy stays high until the stop bit has left the pin.
      busy_d = (state_q != ST_IDLE) || !fifo_empty || push;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Self-checking bench for stdout_uart_tx: frame-timing model plus hand-computed pins.
module tb_stdout_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef STDOUT_UART_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam bit PAR        = 1'b1;
`else
   localparam int FRAME_BITS = 10;
   localparam bit PAR        = 1'b0;
`endif

   logic clk;
   logic rstn;
   logic txd, busy;

   stdout_uart_tx_if bus ();

   stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus),
      .txd  (txd),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: a byte queue plus the edge at which the most recent frame was popped.
   logic [7:0] mq[$];
   int         last_p    = -1000;
   logic [7:0] last_b    = 8'h00;
   logic       exp_txd   = 1'b1;
   logic       exp_busy  = 1'b0;
   logic       exp_ready = 1'b1;
   logic       m_acc     = 1'b0;
   int         m_acc_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef STDOUT_UART_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   initial begin
      bit acc, pop;
      int k;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rstn !== 1'b1) begin
            mq.delete();
            last_p    = -1000;
            exp_txd   = 1'b1;
            exp_busy  = 1'b0;
            exp_ready = 1'b1;
            m_acc     = 1'b0;
         end else begin
            acc = (bus.stdout_write_enable === 1'b1) && (mq.size() < DEPTH);
            pop = (cyc > last_p + FRAME_BITS * CPB) && (mq.size() > 0);
            if (pop) begin
               last_b = mq.pop_front();
               last_p = cyc;
            end
            if (acc) begin
               mq.push_back(bus.stdout_data);
               m_acc_cyc = cyc;
            end
            m_acc     = acc;
            k         = cyc - 1 - last_p;
            exp_txd   = (k >= 0 && k < FRAME_BITS * CPB) ? frame_bit(last_b, k / CPB) : 1'b1;
            exp_busy  = (mq.size() > 0) || (cyc >= last_p && cyc <= last_p + FRAME_BITS * CPB);
            exp_ready = (mq.size() < DEPTH);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rstn === 1'b1) begin
            chk("txd", txd, exp_txd);
            chk("busy", busy, exp_busy);
            chk("ready", bus.stdout_ready, exp_ready);
         end
      end
   end

   // All driver tasks start and return at a falling edge.
   task automatic send(input logic [7:0] b, output int acc_cyc);
      int tries = 0;
      bus.stdout_write_enable = 1'b1;
      bus.stdout_data         = b;
      forever begin
         @(posedge clk);
         #1;
         if (m_acc) break;
         tries++;
         if (tries > 200) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      acc_cyc = m_acc_cyc;
      @(negedge clk);
      bus.stdout_write_enable = 1'b0;
   endtask

   task automatic goto(input int target);
      int g = 0;
      while (cyc < target && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != target) chk("goto", cyc, target);
   endtask

   task automatic drain();
      int g = 0;
      while (busy !== 1'b0 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk("drain_busy", busy, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int a, b, c, acc6;
      int ac[5];
      rstn                    = 1'b0;
      bus.stdout_write_enable = 1'b0;
      bus.stdout_data         = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_txd", txd, 32'd1);
      chk("rst_busy", busy, 32'd0);
      chk("rst_ready", bus.stdout_ready, 32'd1);
      release_reset();
      repeat (2) @(negedge clk);

      // 0x55 from idle: start bit two cycles after accept, then alternating bits.
      send(8'h55, a);
      $display("tx 0x55 accepted at cycle %0d", a);
      chk("p55_busy_acc", busy, 32'd1);
      goto(a + 1);  chk("p55_idle", txd, 32'd1);
      goto(a + 2);  chk("p55_start0", txd, 32'd0);
      goto(a + 5);  chk("p55_start3", txd, 32'd0);
      goto(a + 6);  chk("p55_d0", txd, 32'd1);
      goto(a + 10); chk("p55_d1", txd, 32'd0);
      goto(a + 34); chk("p55_d7", txd, 32'd0);
      goto(a + 38); chk("p55_k9", txd, PAR ? 32'd0 : 32'd1);
      goto(a + 1 + CPB * FRAME_BITS); chk("p55_busy_last", busy, 32'd1);
      goto(a + 2 + CPB * FRAME_BITS); chk("p55_busy_fall", busy, 32'd0);
      drain();

      // Fill a depth-4 buffer with 0x01..0x05, then retry 0x06 against a full buffer.
      for (int i = 0; i < 5; i++) begin
         send(8'(i + 1), ac[i]);
         $display("tx 0x%02h accepted at cycle %0d", i + 1, ac[i]);
         chk("fill_consec", ac[i], ac[0] + i);
         chk("fill_ready", bus.stdout_ready, (i == 4) ? 32'd0 : 32'd1);
      end
      send(8'h06, acc6);
      $display("tx 0x06 accepted at cycle %0d", acc6);
      chk("full_retry_cyc", acc6, ac[0] + 3 + CPB * FRAME_BITS);
      drain();

      // 0xFF then 0x00 back to back: one idle cycle between stop and next start.
      send(8'hFF, b);
      send(8'h00, c);
      $display("tx 0xFF/0x00 accepted at cycles %0d/%0d", b, c);
      chk("b2b_consec", c, b + 1);
      goto(b + 2);  chk("b2b_start1", txd, 32'd0);
      goto(b + 37); chk("b2b_d7", txd, 32'd1);
      goto(b + 1 + CPB * FRAME_BITS); chk("b2b_stop", txd, 32'd1);
      goto(b + 2 + CPB * FRAME_BITS); chk("b2b_idle", txd, 32'd1);
      goto(b + 3 + CPB * FRAME_BITS); chk("b2b_start2", txd, 32'd0);
      goto(b + 6 + CPB * FRAME_BITS); chk("b2b_start2_end", txd, 32'd0);
      goto(b + 7 + CPB * FRAME_BITS); chk("b2b_d0", txd, 32'd0);
      drain();

      // Parity slot: 0x07 has odd weight, 0x03 even weight.
      send(8'h07, a);
      $display("tx 0x07 accepted at cycle %0d", a);
      goto(a + 14); chk("p07_d2", txd, 32'd1);
      goto(a + 34); chk("p07_d7", txd, 32'd0);
      goto(a + 38); chk("p07_k9", txd, 32'd1);
      goto(a + 41); chk("p07_busy_41", busy, 32'd1);
      goto(a + 42); chk("p07_busy_42", busy, PAR ? 32'd1 : 32'd0);
      drain();
      send(8'h03, a);
      $display("tx 0x03 accepted at cycle %0d", a);
      goto(a + 38); chk("p03_k9", txd, PAR ? 32'd0 : 32'd1);
      drain();

      // Reset during data bit 3 of 0xA5 with two bytes still buffered.
      send(8'hA5, a);
      send(8'h11, b);
      send(8'h22, c);
      $display("tx 0xA5/0x11/0x22 accepted at cycles %0d/%0d/%0d", a, b, c);
      goto(a + 18); chk("a5_d3", txd, 32'd0);
      chk("a5_busy", busy, 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_txd", txd, 32'd1);
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_ready", bus.stdout_ready, 32'd1);
      repeat (3) @(negedge clk);
      release_reset();
      repeat (100) @(negedge clk);
      chk("post_rst_txd", txd, 32'd1);
      chk("post_rst_busy", busy, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
